jt5205_seq: RTL and testbench

- ADPCM sample sequencer that sits between the sound CPU, the ADPCM sample ROM and the jt5205 decoder.
- On a CPU trigger it fetches bytes from ROM between a start page and an end page. It splits each byte into two nibbles and presents one nibble to the decoder per decoder sample strobe (irq/cen_lo).
- It holds the decoder in reset while idle, and double-buffers one byte so ROM latency does not starve the decoder.

---
 rtl/jt5205_seq_pkg.sv | 24 ++
 rtl/jt5205_seq_if.sv | 31 +++
 rtl/jt5205_seq_fetch.sv | 83 ++++++++
 rtl/jt5205_seq.sv | 176 +++++++++++++++++
 tb/tb_jt5205_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt5205_seq_pkg.sv
// jt5205_seq_pkg
// Shared definitions for the ADPCM sample sequencer:
//   state_t     - sequencer FSM states
//   PAGE_LSB    - bit position of the page field inside a ROM byte address
//   nibble_sel  - picks the nibble of a ROM byte that plays in a given phase
package jt5205_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PLAY_A,
    PLAY_B
  } state_t;

  localparam int PAGE_LSB = 8;

  // phase 0 is the first nibble played out of a byte, phase 1 the second.
  function automatic logic [3:0] nibble_sel(input logic [7:0] b,
                                            input logic       phase,
                                            input bit         hi_first);
    return (phase ^ ~hi_first) ? b[3:0] : b[7:4];
  endfunction

endpackage

// File: rtl/jt5205_seq_if.sv
// jt5205_seq_if
// ADPCM sample ROM read bus.
//   rom_addr - byte address
//   rom_cs   - read request, held until rom_ok
//   rom_data - ROM byte, valid when rom_ok
//   rom_ok   - ROM data valid
// master: sequencer side; slave: ROM side.
interface jt5205_seq_if #(
  parameter int ADDRW = 16
) ();

  logic [ADDRW-1:0] rom_addr;
  logic             rom_cs;
  logic [7:0]       rom_data;
  logic             rom_ok;

  modport master (
    output rom_addr,
    output rom_cs,
    input  rom_data,
    input  rom_ok
  );

  modport slave (
    input  rom_addr,
    input  rom_cs,
    output rom_data,
    output rom_ok
  );

endinterface

// File: rtl/jt5205_seq_fetch.sv
// jt5205_seq_fetch
// ROM fetch engine for the ADPCM sequencer: byte address counter, end-of-sample
// compare, rom_cs/rom_ok handshake and the one-byte prefetch buffer (nxt).
//   clk, rst   - clock, synchronous active-low reset
//   restart    - load address from start_pg and request the first byte
//   flush      - drop any pending request and invalidate nxt
//   start_pg   - page to start from (used with restart)
//   end_pg     - page holding the last byte of the sample
//   fetch_en   - prefetch allowed (issued only when nxt is empty and bytes remain)
//   want_cur   - the byte now arriving goes straight to the player, not to nxt
//   nxt_take   - player consumed nxt
//   byte_ok    - a requested byte is accepted this cycle
//   rd_data    - the arriving byte
//   nxt        - prefetched byte, nxt_valid marks it present
//   done       - the last byte of the sample has been fetched
//   rom        - ROM bus (master)
module jt5205_seq_fetch
  import jt5205_seq_pkg::*;
#(
  parameter int ADDRW = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      restart,
  input  logic                      flush,
  input  logic [ADDRW-PAGE_LSB-1:0] start_pg,
  input  logic [ADDRW-PAGE_LSB-1:0] end_pg,
  input  logic                      fetch_en,
  input  logic                      want_cur,
  input  logic                      nxt_take,
  output logic                      byte_ok,
  output logic [7:0]                rd_data,
  output logic [7:0]                nxt,
  output logic                      nxt_valid,
  output logic                      done,
  jt5205_seq_if.master              rom
);

  logic [ADDRW-1:0] addr;
  logic [ADDRW-1:0] last_addr;
  logic             cs;

  assign last_addr    = {end_pg, {PAGE_LSB{1'b1}}};
  // A rom_ok without an outstanding request (e.g. after a stop) is ignored.
  assign byte_ok      = cs & rom.rom_ok;
  assign rd_data      = rom.rom_data;
  assign rom.rom_addr = addr;
  assign rom.rom_cs   = cs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr      <= '0;
      cs        <= 1'b0;
      nxt       <= '0;
      nxt_valid <= 1'b0;
      done      <= 1'b0;
    end else if (flush) begin
      cs        <= 1'b0;
      nxt_valid <= 1'b0;
    end else if (restart) begin
      addr      <= {start_pg, {PAGE_LSB{1'b0}}};
      cs        <= 1'b1;
      nxt_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (nxt_take) nxt_valid <= 1'b0;
      if (byte_ok) begin
        cs   <= 1'b0;
        addr <= addr + 1'b1;
        // The end page is compared per fetched byte, so a late end_wr
        // applies from the next fetch on.
        done <= (addr == last_addr);
        if (!want_cur) begin
          nxt       <= rom.rom_data;
          nxt_valid <= 1'b1;
        end
      end else if (fetch_en && !cs && !nxt_valid && !done) begin
        cs <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/jt5205_seq.sv
// jt5205_seq
// ADPCM sample sequencer between the sound CPU, the ADPCM sample ROM and the
// jt5205 decoder. Plays ROM bytes from {start_pg,00} to {end_pg,FF} as nibbles,
// one per decoder sample strobe, with one byte of prefetch.
//   clk, rst   - clock, synchronous active-low reset
//   cpu_din    - CPU write data (page number in the low ADDRW-8 bits)
//   start_wr   - load start page and (re)trigger playback
//   end_wr     - load end page
//   stop_wr    - abort playback
//   adpcm_irq  - decoder sample strobe
//   rom        - ROM read bus (master)
//   adpcm_din  - nibble to the decoder
//   adpcm_rst  - decoder reset (1 = held in reset)
//   playing    - sample active
//   underrun   - sticky starvation flag, cleared by start_wr
module jt5205_seq
  import jt5205_seq_pkg::*;
#(
  parameter int ADDRW    = 16,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   cpu_din,
  input  logic         start_wr,
  input  logic         end_wr,
  input  logic         stop_wr,
  input  logic         adpcm_irq,
  jt5205_seq_if.master rom,
  output logic [3:0]   adpcm_din,
  output logic         adpcm_rst,
  output logic         playing,
  output logic         underrun
);

  localparam int PW = ADDRW - PAGE_LSB;

  state_t        state, state_nx;
  logic [PW-1:0] end_pg;
  logic [7:0]    cur, cur_nx;
  logic          starve, starve_nx;
  logic          underrun_nx;
  logic [3:0]    din_nx;
  logic          play_nx;

  logic          restart, flush, fetch_en, want_cur, nxt_take;
  logic          byte_ok, nxt_valid, done;
  logic [7:0]    rd_data, nxt;

  jt5205_seq_fetch #(
    .ADDRW (ADDRW)
  ) u_fetch (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .flush     (flush),
    .start_pg  (PW'(cpu_din)),
    .end_pg    (end_pg),
    .fetch_en  (fetch_en),
    .want_cur  (want_cur),
    .nxt_take  (nxt_take),
    .byte_ok   (byte_ok),
    .rd_data   (rd_data),
    .nxt       (nxt),
    .nxt_valid (nxt_valid),
    .done      (done),
    .rom       (rom)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    cur_nx      = cur;
    starve_nx   = starve;
    underrun_nx = underrun;
    din_nx      = adpcm_din;
    restart     = 1'b0;
    flush       = 1'b0;
    fetch_en    = 1'b0;
    want_cur    = 1'b0;
    nxt_take    = 1'b0;

    if (stop_wr) begin
      state_nx  = IDLE;
      flush     = 1'b1;
      starve_nx = 1'b0;
    end else if (start_wr) begin
      state_nx    = FILL;
      restart     = 1'b1;
      starve_nx   = 1'b0;
      underrun_nx = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        FILL: begin
          want_cur = 1'b1;
          if (byte_ok) begin
            cur_nx   = rd_data;
            din_nx   = nibble_sel(rd_data, 1'b0, HI_FIRST);
            state_nx = PLAY_A;
          end
        end
        PLAY_A: begin
          fetch_en = 1'b1;
          if (adpcm_irq) begin
            din_nx   = nibble_sel(cur, 1'b1, HI_FIRST);
            state_nx = PLAY_B;
          end
        end
        PLAY_B: begin
          fetch_en = 1'b1;
          if (starve) begin
            // Starved: strobes are ignored until the missing byte lands.
            want_cur = 1'b1;
            if (byte_ok) begin
              cur_nx    = rd_data;
              din_nx    = nibble_sel(rd_data, 1'b0, HI_FIRST);
              starve_nx = 1'b0;
              state_nx  = PLAY_A;
            end
          end else if (adpcm_irq) begin
            if (nxt_valid) begin
              cur_nx   = nxt;
              nxt_take = 1'b1;
              din_nx   = nibble_sel(nxt, 1'b0, HI_FIRST);
              state_nx = PLAY_A;
            end else if (done) begin
              state_nx = IDLE;
              flush    = 1'b1;
            end else begin
              // A byte landing on the same strobe is used directly.
              want_cur = 1'b1;
              if (byte_ok) begin
                cur_nx   = rd_data;
                din_nx   = nibble_sel(rd_data, 1'b0, HI_FIRST);
                state_nx = PLAY_A;
              end else begin
                underrun_nx = 1'b1;
                starve_nx   = 1'b1;
                din_nx      = 4'h0;
              end
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    play_nx = (state_nx == PLAY_A) || (state_nx == PLAY_B);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      end_pg    <= '0;
      cur       <= '0;
      starve    <= 1'b0;
      underrun  <= 1'b0;
      adpcm_din <= '0;
      adpcm_rst <= 1'b1;
      playing   <= 1'b0;
    end else begin
      if (end_wr) end_pg <= PW'(cpu_din);
      cur       <= cur_nx;
      starve    <= starve_nx;
      underrun  <= underrun_nx;
      adpcm_din <= din_nx;
      adpcm_rst <= ~play_nx;
      playing   <= play_nx;
    end
  end

endmodule

// File: tb/tb_jt5205_seq.sv
module tb_jt5205_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_din;
  logic       start_wr, end_wr, stop_wr, adpcm_irq, start0;
  logic [3:0] din1, din0;
  logic       arst1, play1, und1, arst0, play0, und0;

  int checks   = 0;
  int failures = 0;

  jt5205_seq_if #(.ADDRW(16)) rom1 ();
  jt5205_seq_if #(.ADDRW(16)) rom0 ();

  jt5205_seq #(.ADDRW(16), .HI_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .cpu_din(cpu_din), .start_wr(start_wr),
    .end_wr(end_wr), .stop_wr(stop_wr), .adpcm_irq(adpcm_irq), .rom(rom1),
    .adpcm_din(din1), .adpcm_rst(arst1), .playing(play1), .underrun(und1)
  );

  jt5205_seq #(.ADDRW(16), .HI_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .cpu_din(cpu_din), .start_wr(start0),
    .end_wr(end_wr), .stop_wr(stop_wr), .adpcm_irq(adpcm_irq), .rom(rom0),
    .adpcm_din(din0), .adpcm_rst(arst0), .playing(play0), .underrun(und0)
  );

  // Second ROM: always 0xA5, answers in the same cycle as the request.
  assign rom0.rom_data = 8'hA5;
  assign rom0.rom_ok   = rom0.rom_cs;

  always #5 clk = ~clk;

  // ROM pattern: byte k of a page = {2k+1, 2k+2} (mod 16 each) -> 0x12,0x34,...
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    int k;
    k = int'(a[7:0]);
    return {4'(2 * k + 1), 4'(2 * k + 2)};
  endfunction

  // Main ROM model with programmable latency; it answers every captured
  // request even if rom_cs has since dropped.
  int          rom_lat = 1;
  bit          rom_busy = 1'b0;
  int          rom_cnt;
  logic [15:0] rom_cap;

  initial begin
    rom1.rom_ok   = 1'b0;
    rom1.rom_data = 8'h00;
    forever begin
      @(negedge clk);
      rom1.rom_ok = 1'b0;
      if (rom_busy) begin
        if (rom_cnt == 0) begin
          rom1.rom_ok   = 1'b1;
          rom1.rom_data = rom_byte(rom_cap);
          rom_busy      = 1'b0;
        end else begin
          rom_cnt--;
        end
      end else if (rom1.rom_cs) begin
        rom_busy = 1'b1;
        rom_cap  = rom1.rom_addr;
        rom_cnt  = rom_lat;
      end
    end
  end

  // Request monitor, updated once per cycle by step().
  logic [15:0] mon_addr = 16'h0;
  int          req_cnt  = 0;
  int          addr_err = 0;
  logic        prev_cs  = 1'b0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rom1.rom_cs && !prev_cs) begin
        if (rom1.rom_addr !== mon_addr) addr_err++;
        mon_addr = mon_addr + 16'd1;
        req_cnt++;
      end
      prev_cs = rom1.rom_cs;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic irq_pulse();
    adpcm_irq = 1'b1;
    step(1);
    adpcm_irq = 1'b0;
  endtask

  task automatic wait_play(input int limit, output bit ok);
    ok = play1;
    for (int i = 0; i < limit && !ok; i++) begin
      step(1);
      ok = play1;
    end
  endtask

  task automatic mon_clear(input logic [15:0] a);
    mon_addr = a;
    req_cnt  = 0;
    addr_err = 0;
  endtask

  // Plays u1 to completion with one strobe every per cycles; returns the number
  // of nibbles played (-1 if playback never began) and nibble mismatches.
  task automatic run_play(input int per, input int max_nib, output int nib, output int err);
    bit ok;
    nib = 0;
    err = 0;
    wait_play(300, ok);
    if (!ok) begin
      nib = -1;
      return;
    end
    while (play1 && nib < max_nib) begin
      if (din1 !== 4'(nib + 1)) err++;
      step(per - 1);
      if (din1 !== 4'(nib + 1)) err++;
      irq_pulse();
      nib++;
    end
  endtask

  task automatic write_end(input logic [7:0] pg);
    cpu_din = pg;
    end_wr  = 1'b1;
    step(1);
    end_wr  = 1'b0;
  endtask

  task automatic write_start(input logic [7:0] pg);
    cpu_din  = pg;
    start_wr = 1'b1;
    step(1);
    start_wr = 1'b0;
  endtask

  task automatic do_stop();
    stop_wr = 1'b1;
    step(1);
    stop_wr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nib, err;
    bit          ok;
    logic [3:0]  din_s;
    logic [15:0] addr_s;

    rst = 1'b0; cpu_din = 8'h00;
    start_wr = 1'b0; end_wr = 1'b0; stop_wr = 1'b0; adpcm_irq = 1'b0; start0 = 1'b0;
    step(3);

    // Reset state
    chk("rst_cs",    32'(rom1.rom_cs),   32'h0);
    chk("rst_addr",  32'(rom1.rom_addr), 32'h0);
    chk("rst_din",   32'(din1),          32'h0);
    chk("rst_arst",  32'(arst1),         32'h1);
    chk("rst_play",  32'(play1),         32'h0);
    chk("rst_und",   32'(und1),          32'h0);
    chk("rst_arst0", 32'(arst0),         32'h1);
    rst = 1'b1;
    step(2);

    // Single page 0x01, HI_FIRST=1: nibbles 1,2,3,... x512
    rom_lat = 1;
    write_end(8'h01);
    mon_clear(16'h0100);
    write_start(8'h01);
    chk("p1_cs_n1",  32'(rom1.rom_cs),   32'h1);
    chk("p1_addr",   32'(rom1.rom_addr), 32'h0100);
    chk("p1_fill_p", 32'(play1),         32'h0);
    chk("p1_fill_r", 32'(arst1),         32'h1);
    run_play(8, 600, nib, err);
    chk("p1_nibs",   32'(nib),           32'd512);
    chk("p1_niberr", 32'(err),           32'd0);
    chk("p1_end_r",  32'(arst1),         32'h1);
    chk("p1_end_p",  32'(play1),         32'h0);
    chk("p1_reqs",   32'(req_cnt),       32'd256);
    chk("p1_adrerr", 32'(addr_err),      32'd0);
    chk("p1_cs_off", 32'(rom1.rom_cs),   32'h0);
    chk("p1_und",    32'(und1),          32'h0);

    // HI_FIRST=0 with byte 0xA5: 5 then A
    write_end(8'h05);
    cpu_din = 8'h05;
    start0  = 1'b1;
    step(1);
    start0  = 1'b0;
    ok = play0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1);
      ok = play0;
    end
    chk("lo_play",  32'(ok),   32'h1);
    chk("lo_nib0",  32'(din0), 32'h5);
    step(3);
    irq_pulse();
    chk("lo_nib1",  32'(din0), 32'hA);
    step(3);
    irq_pulse();
    chk("lo_nib2",  32'(din0), 32'h5);
    do_stop();
    chk("lo_stop",  32'(play0), 32'h0);

    // Underrun: ROM latency 40 cycles, strobe every 15 cycles
    rom_lat = 38;
    write_end(8'h02);
    write_start(8'h02);
    wait_play(100, ok);
    chk("ur_play",  32'(ok),   32'h1);
    chk("ur_nib0",  32'(din1), 32'h1);
    step(14);
    irq_pulse();
    chk("ur_nib1",  32'(din1), 32'h2);
    chk("ur_none",  32'(und1), 32'h0);
    step(14);
    irq_pulse();
    chk("ur_flag",  32'(und1), 32'h1);
    chk("ur_zero",  32'(din1), 32'h0);
    step(5);
    chk("ur_gap",   32'(din1), 32'h0);
    chk("ur_gap_p", 32'(play1), 32'h1);
    for (int i = 0; i < 60 && din1 === 4'h0; i++) step(1);
    chk("ur_resume", 32'(din1), 32'h3);
    chk("ur_sticky", 32'(und1), 32'h1);
    do_stop();
    step(50);

    // stop_wr with a prefetch outstanding; the late rom_ok changes nothing
    rom_lat = 28;
    write_end(8'h03);
    write_start(8'h03);
    chk("st_und_clr", 32'(und1), 32'h0);
    wait_play(100, ok);
    chk("st_play", 32'(ok), 32'h1);
    for (int i = 0; i < 10 && !rom1.rom_cs; i++) step(1);
    step(3);
    chk("st_cs_pend", 32'(rom1.rom_cs), 32'h1);
    do_stop();
    chk("st_cs",   32'(rom1.rom_cs), 32'h0);
    chk("st_play0", 32'(play1),      32'h0);
    chk("st_arst", 32'(arst1),       32'h1);
    din_s  = din1;
    addr_s = rom1.rom_addr;
    step(40);
    chk("st_late_cs",   32'(rom1.rom_cs),   32'h0);
    chk("st_late_p",    32'(play1),         32'h0);
    chk("st_late_r",    32'(arst1),         32'h1);
    chk("st_late_din",  32'(din1),          32'(din_s));
    chk("st_late_addr", 32'(rom1.rom_addr), 32'(addr_s));

    // stop_wr beats start_wr in the same cycle
    cpu_din  = 8'h07;
    start_wr = 1'b1;
    stop_wr  = 1'b1;
    step(1);
    start_wr = 1'b0;
    stop_wr  = 1'b0;
    chk("ss_cs",   32'(rom1.rom_cs),   32'h0);
    chk("ss_arst", 32'(arst1),         32'h1);
    chk("ss_addr", 32'(rom1.rom_addr), 32'(addr_s));
    step(2);

    // Wrap: start 0xFF, end 0x00 -> 0xFF00..0xFFFF, 0x0000..0x00FF
    rom_lat = 1;
    write_end(8'h00);
    mon_clear(16'hFF00);
    write_start(8'hFF);
    chk("wr_addr0", 32'(rom1.rom_addr), 32'hFF00);
    run_play(6, 1100, nib, err);
    chk("wr_nibs",   32'(nib),           32'd1024);
    chk("wr_niberr", 32'(err),           32'd0);
    chk("wr_reqs",   32'(req_cnt),       32'd512);
    chk("wr_adrerr", 32'(addr_err),      32'd0);
    chk("wr_next",   32'(rom1.rom_addr), 32'h0100);
    chk("wr_idle",   32'(play1),         32'h0);

    // start_wr and end_wr together: both pages load
    mon_clear(16'h0600);
    cpu_din  = 8'h06;
    start_wr = 1'b1;
    end_wr   = 1'b1;
    step(1);
    start_wr = 1'b0;
    end_wr   = 1'b0;
    chk("se_addr", 32'(rom1.rom_addr), 32'h0600);
    run_play(4, 600, nib, err);
    chk("se_nibs", 32'(nib),     32'd512);
    chk("se_reqs", 32'(req_cnt), 32'd256);

    // Restart while playing: decoder reset pulse, new start page
    write_start(8'h06);
    wait_play(50, ok);
    step(6);
    write_start(8'h02);
    chk("rs_arst", 32'(arst1),         32'h1);
    chk("rs_play", 32'(play1),         32'h0);
    chk("rs_addr", 32'(rom1.rom_addr), 32'h0200);
    wait_play(50, ok);
    chk("rs_arst1", 32'(arst1), 32'h0);
    chk("rs_nib0",  32'(din1),  32'h1);
    do_stop();
    step(5);

    // Reset pulse during PLAY_B, then normal playback
    write_end(8'h04);
    write_start(8'h04);
    wait_play(50, ok);
    irq_pulse();
    chk("rb_nib1", 32'(din1), 32'h2);
    rst = 1'b0;
    step(1);
    chk("rb_cs",   32'(rom1.rom_cs),   32'h0);
    chk("rb_addr", 32'(rom1.rom_addr), 32'h0);
    chk("rb_din",  32'(din1),          32'h0);
    chk("rb_arst", 32'(arst1),         32'h1);
    chk("rb_play", 32'(play1),         32'h0);
    chk("rb_und",  32'(und1),          32'h0);
    rst = 1'b1;
    step(5);
    write_end(8'h01);
    mon_clear(16'h0100);
    write_start(8'h01);
    run_play(4, 600, nib, err);
    chk("rb_nibs",   32'(nib),      32'd512);
    chk("rb_niberr", 32'(err),      32'd0);
    chk("rb_adrerr", 32'(addr_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
